// File: rtl/gpp_pkg.sv
// Shared definitions for the return-address stack and the PC datapath.
package gpp_pkg;

   localparam int ADDR_W    = 16;
   localparam int RAS_DEPTH = 8;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

   // Encoded as {push, pop} so the request pair casts directly.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// DEPTH x AW register array: one synchronous write port, one asynchronous read port.
module ras_mem #(
   parameter int AW    = 16,
   parameter int DEPTH = 8,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [AW-1:0] wdata,
   input  logic [IW-1:0] raddr,
   output logic [AW-1:0] rdata
);

   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack feeding the PC load input; top is a 0-latency read.
// Build option: RAS_OVF_WRAP_EN makes the stack circular (push while full drops the oldest entry).
module ret_addr_stack
   import gpp_pkg::*;
#(
   parameter  int AW    = ADDR_W,
   parameter  int DEPTH = RAS_DEPTH,
   localparam int PW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   input  logic          clr_err,
   output logic [AW-1:0] top,
   output logic [PW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underflow
);

   localparam int IW = PW - 1;

   logic [PW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] base_q, base_d;
   logic [IW-1:0] wr_idx, top_idx, waddr;
   logic [PW-1:0] top_sum;
   logic [AW-1:0] rdata;
   logic          we;
   err_flags_t    err_q, err_d;
   ras_op_e       op;

   // Entries live at base..base+cnt-1 modulo DEPTH; base only moves in the circular build.
   assign wr_idx  = base_q + cnt_q[IW-1:0];
   assign top_sum = {1'b0, base_q} + cnt_q - PW'(1);
   assign top_idx = top_sum[IW-1:0];

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == PW'(DEPTH));
   assign count     = cnt_q;
   assign top       = empty ? '0 : rdata;
   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;

   always_comb begin
      op     = ras_op_e'({push, pop});
      cnt_d  = cnt_q;
      base_d = base_q;
      we     = 1'b0;
      waddr  = wr_idx;
      err_d  = clr_err ? '0 : err_q;
      case (op)
         OP_PUSH: begin
            if (!full) begin
               we    = 1'b1;
               cnt_d = cnt_q + PW'(1);
            end else begin
               err_d.overflow = 1'b1;
`ifdef RAS_OVF_WRAP_EN
               we     = 1'b1;
               base_d = base_q + IW'(1);
`endif
            end
         end
         OP_POP: begin
            if (!empty) cnt_d = cnt_q - PW'(1);
            else        err_d.underflow = 1'b1;
         end
         OP_REPL: begin
            we = 1'b1;
            if (!empty) begin
               waddr = top_idx;
            end else begin
               cnt_d           = PW'(1);
               err_d.underflow = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         base_q <= '0;
         err_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         base_q <= base_d;
         err_q  <= err_d;
      end
   end

   ras_mem #(
      .AW   (AW),
      .DEPTH(DEPTH),
      .IW   (IW)
   ) u_mem (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .waddr(waddr),
      .wdata(push_data),
      .raddr(top_idx),
      .rdata(rdata)
   );

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: directed scenarios plus random traffic against a queue model.
module tb_ret_addr_stack;

   localparam int AW    = 16;
   localparam int DEPTH = 8;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [AW-1:0] push_data = '0;
   logic          clr_err = 1'b0;
   logic [AW-1:0] top;
   logic [PW-1:0] count;
   logic          empty, full, overflow, underflow;

   int n_checks = 0;
   int n_pass   = 0;

   logic [AW-1:0] mq[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   ret_addr_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
      .clr_err(clr_err), .top(top), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic p, input logic o, input logic [AW-1:0] d, input logic c);
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && o) begin
         if (mq.size() > 0) mq[mq.size()-1] = d;
         else begin
            mq.push_back(d);
            m_unf = 1'b1;
         end
      end else if (p) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else begin
            m_ovf = 1'b1;
`ifdef RAS_OVF_WRAP_EN
            void'(mq.pop_front());
            mq.push_back(d);
`endif
         end
      end else if (o) begin
         if (mq.size() > 0) void'(mq.pop_back());
         else m_unf = 1'b1;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic cycle(input logic p, input logic o, input logic [AW-1:0] d, input logic c);
      push = p; pop = o; push_data = d; clr_err = c;
      @(posedge clk);
      model_step(p, o, d, c);
      #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic hard_reset();
      #2 rst = 1'b1;
      model_reset();
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk) rst = 1'b0;
      cycle(1'b1, 1'b0, 16'hA5A5, 1'b0);
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      cycle(1'b1, 1'b0, 16'h1234, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (top !== 16'h0000) $display("FAIL reset_top: got %h want 0000", top); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1 || full !== 1'b0)
         $display("FAIL reset_empty_full: got %b%b want 10", empty, full); else n_pass++;
      n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); else n_pass++;
      model_reset();
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      cycle(1'b1, 1'b0, 16'h6AB3, 1'b0);
      cycle(1'b1, 1'b0, 16'h87AB, 1'b0);
      n_checks++; if (top !== 16'h87AB || count !== PW'(2))
         $display("FAIL push2: got top=%h count=%0d want 87ab/2", top, count); else n_pass++;
      pop = 1'b1; #1;
      n_checks++; if (top !== 16'h87AB) $display("FAIL pop1_sameCycle: got %h want 87ab", top); else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (top !== 16'h6AB3 || count !== PW'(1))
         $display("FAIL pop1: got top=%h count=%0d want 6ab3/1", top, count); else n_pass++;
      pop = 1'b1; #1;
      n_checks++; if (top !== 16'h6AB3) $display("FAIL pop2_sameCycle: got %h want 6ab3", top); else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (empty !== 1'b1 || top !== 16'h0000 || underflow !== 1'b0)
         $display("FAIL pop2: got empty=%b top=%h unf=%b want 1/0000/0", empty, top, underflow); else n_pass++;
   endtask

   task automatic test_fill_overflow();
      logic [AW-1:0] exp;
      for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, AW'(i), 1'b0);
      n_checks++; if (full !== 1'b1 || count !== PW'(DEPTH) || overflow !== 1'b0)
         $display("FAIL fill: got full=%b count=%0d ovf=%b want 1/8/0", full, count, overflow); else n_pass++;
      cycle(1'b1, 1'b0, 16'h0009, 1'b0);
`ifdef RAS_OVF_WRAP_EN
      exp = 16'h0009;
`else
      exp = 16'h0008;
`endif
      n_checks++; if (count !== PW'(DEPTH) || top !== exp || overflow !== 1'b1)
         $display("FAIL push_full: got count=%0d top=%h ovf=%b want 8/%h/1", count, top, overflow, exp); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         exp = exp - AW'(i == 0 ? 0 : 1);
         n_checks++; if (top !== exp) $display("FAIL drain_%0d: got %h want %h", i, top, exp); else n_pass++;
         cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      end
      n_checks++; if (empty !== 1'b1 || overflow !== 1'b1)
         $display("FAIL drained: got empty=%b ovf=%b want 1/1", empty, overflow); else n_pass++;
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_underflow_clr();
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (underflow !== 1'b1 || count !== '0 || top !== 16'h0000)
         $display("FAIL unf_set: got unf=%b count=%0d top=%h want 1/0/0000", underflow, count, top); else n_pass++;
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      n_checks++; if (underflow !== 1'b0) $display("FAIL unf_clear: got %b want 0", underflow); else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b1);
      n_checks++; if (underflow !== 1'b1) $display("FAIL unf_clr_race: got %b want 1", underflow); else n_pass++;
      cycle(1'b1, 1'b1, 16'h4321, 1'b1);
      n_checks++; if (underflow !== 1'b1 || count !== PW'(1) || top !== 16'h4321)
         $display("FAIL repl_empty: got unf=%b count=%0d top=%h want 1/1/4321", underflow, count, top); else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b1);
      n_checks++; if (underflow !== 1'b0 || empty !== 1'b1)
         $display("FAIL unf_final: got unf=%b empty=%b want 0/1", underflow, empty); else n_pass++;
   endtask

   task automatic test_replace();
      cycle(1'b1, 1'b0, 16'h1111, 1'b0);
      cycle(1'b1, 1'b0, 16'h2222, 1'b0);
      cycle(1'b1, 1'b1, 16'h8400, 1'b0);
      n_checks++; if (count !== PW'(2) || top !== 16'h8400 || overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL replace: got count=%0d top=%h flags=%b%b want 2/8400/00", count, top, overflow, underflow);
      else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (top !== 16'h1111) $display("FAIL replace_pop: got %h want 1111", top); else n_pass++;
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 1'b0, 16'hAAAA, 1'b0);
      cycle(1'b1, 1'b0, 16'hBBBB, 1'b0);
      cycle(1'b1, 1'b0, 16'hCCCC, 1'b0);
      push = 1'b1; push_data = 16'hDDDD;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      n_checks++; if (count !== '0 || top !== 16'h0000)
         $display("FAIL reset_mid: got count=%0d top=%h want 0/0000", count, top); else n_pass++;
      @(negedge clk) begin rst = 1'b0; push = 1'b0; end
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (underflow !== 1'b1 || count !== '0)
         $display("FAIL reset_mid_pop: got unf=%b count=%0d want 1/0", underflow, count); else n_pass++;
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
   endtask

   task automatic test_random();
      logic          p, o, c;
      logic [AW-1:0] d, et;
      for (int i = 0; i < 600; i++) begin
         p = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3));
         o = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7));
         c = ($urandom_range(0, 15) == 0);
         d = AW'($urandom);
         if (o && mq.size() > 0) begin
            #1;
            pop = 1'b1; #1;
            n_checks++; if (top !== mq[mq.size()-1])
               $display("FAIL rnd_pop_read_%0d: got %h want %h", i, top, mq[mq.size()-1]); else n_pass++;
         end
         cycle(p, o, d, c);
         et = (mq.size() > 0) ? mq[mq.size()-1] : '0;
         n_checks++; if (top !== et) $display("FAIL rnd_top_%0d: got %h want %h", i, top, et); else n_pass++;
         n_checks++; if (count !== PW'(mq.size()))
            $display("FAIL rnd_count_%0d: got %0d want %0d", i, count, mq.size()); else n_pass++;
         n_checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
            $display("FAIL rnd_ef_%0d: got %b%b want %b%b", i, empty, full, mq.size() == 0, mq.size() == DEPTH);
         else n_pass++;
         n_checks++; if (overflow !== m_ovf || underflow !== m_unf)
            $display("FAIL rnd_flags_%0d: got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf); else n_pass++;
      end
      hard_reset();
      n_checks++; if (count !== '0 || overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL rnd_final_reset: got count=%0d flags=%b%b want 0/00", count, overflow, underflow);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_underflow_clr();
      test_replace();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack that sits directly upstream of the program counter and drives its load input.
- On a CALL the sequencer pushes the return address. On a RET it pops, and `top` is presented combinationally so the PC can load it in the same cycle its STACK_POP is asserted.
- The PC applies its own post-pop offset; this block stores and returns raw 16-bit addresses only.

Parameters:
- AW, 16, address width; must match the PC width.
- DEPTH, 8, number of entries; power of two, at least 2.
- PW, $clog2(DEPTH)+1, width of the stack-pointer/count register (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  push `push_data` this cycle (CALL).
- pop  in  1  pop the top entry this cycle (RET); shares its source with the PC's STACK_POP.
- push_data  in  AW  return address to store.
- clr_err  in  1  synchronous clear of the sticky error flags.
- top  out  AW  current top entry (mem[sp-1]); combinational from registers.
- count  out  PW  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (async, rst=1): sp=0, overflow=0, underflow=0, all mem entries=0. Therefore top=0, count=0, empty=1, full=0. Reset asserted mid-operation aborts any push/pop that edge.
- sp is the next free slot; count=sp; top=mem[sp-1]. When empty, top=0 (forced, not stale data).
- Latency: a push is visible on `top` the cycle after the edge. A pop consumes the current `top` in the same cycle (0-latency read); the next entry appears after the edge.
- Only push=1, not full: mem[sp]<=push_data; sp<=sp+1.
- Only push=1, full: no write, sp unchanged, overflow<=1.
- Only pop=1, not empty: sp<=sp-1. The entry is not cleared.
- Only pop=1, empty: sp stays 0, underflow<=1, top stays 0.
- push=1 and pop=1, not empty: replace the top, i.e. mem[sp-1]<=push_data with sp unchanged (tail-call). No error flag, even when full.
- push=1 and pop=1, empty: treated as push only; sp<=1; underflow<=1.
- clr_err=1: overflow and underflow <=0. A new error in the same cycle wins (flag set).
- Flags change only on a clock edge or reset; no glitch paths on count/empty/full.

Optional Feature:
- Macro: RAS_OVF_WRAP_EN.
- Defined:
  - The stack is circular. A push while full overwrites the oldest entry: mem[wr_ptr] written, base pointer advances, count stays DEPTH.
  - overflow is still set (sticky) to flag lost history.
  - Pops return the newest DEPTH addresses correctly.
  - Requires separate head/base pointers modulo DEPTH.
- Undefined: a push while full is dropped as specified above.

Decomposition:
- Shared package (gpp_pkg): ADDR_W=16 constant shared with the PC, default RAS_DEPTH, and an error-flag typedef/struct {overflow, underflow}.
- One natural sub-module: ras_mem, a DEPTH x AW register array with one write port and one asynchronous read port. Pointer/count/flag logic stays in the top.

Test Plan:
- Reset: assert rst=1 async between edges -> top=0x0000, count=0, empty=1, full=0, both flags 0, immediately (no clock needed).
- Push 0x6AB3 then 0x87AB -> top=0x87AB, count=2. Pop -> top=0x6AB3 same cycle as second pop request, count=1. Pop -> empty=1, top=0.
- Fill DEPTH=8 with 0x0001..0x0008 -> full=1. 9th push 0x0009 -> count=8, top=0x0008, overflow=1. With RAS_OVF_WRAP_EN: top=0x0009, popping all returns 0x0009..0x0002.
- Pop while empty -> underflow=1, count=0. clr_err=1 one cycle -> underflow=0. Same-cycle clr_err with empty pop -> underflow stays 1.
- Stack {0x1111,0x2222}: push=pop=1 with 0x8400 -> count=2, top=0x8400; next pop -> top=0x1111.
- Reset mid-sequence: 3 pushes, assert rst during a push cycle -> count=0, write discarded; after release, first pop -> underflow=1.
